mem_arbiter: RTL and testbench

Three-way request arbiter and sequencer in front of the byte-serial memory controller. Collects requests from the load/store buffer, the instruction-cache refill path and an optional next-line prefetcher, and grants exactly one at a time onto a single downstream request channel. Handles starvation ageing and rollback. Sits between IFetch/ICache/LSB and the memory controller.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of LSB / IF refill / prefetch onto a single downstream channel.
// Build with PREFETCH_EN defined to add the next-line prefetch requester (pf_*).
module mem_arbiter #(
   parameter int LINE_BYTES   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    rollback,
   input  logic                    lsb_req,
   input  logic                    lsb_wr,
   input  logic [31:0]             lsb_addr,
   input  logic [2:0]              lsb_len,
   input  logic [31:0]             lsb_wdata,
   output logic                    lsb_done,
   output logic [31:0]             lsb_rdata,
   input  logic                    if_req,
   input  logic [31:0]             if_addr,
   output logic                    if_done,
`ifdef PREFETCH_EN
   input  logic                    pf_req,
   input  logic [31:0]             pf_addr,
   output logic                    pf_done,
`endif
   output logic [LINE_BYTES*8-1:0] rd_line,
   output logic                    dn_en,
   output logic                    dn_wr,
   output logic [31:0]             dn_addr,
   output logic [6:0]              dn_len,
   output logic [31:0]             dn_wdata,
   input  logic                    dn_done,
   input  logic [LINE_BYTES*8-1:0] dn_rdata,
   output logic [1:0]              fsm_state
);

   // Handshake: a requester holds *_req and its operands until its done pulse;
   // dn_en is held with all dn_* stable until dn_done, and rdy low freezes every register.
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_LSB = 2'd0, OWN_IF = 2'd1, OWN_PF = 2'd2, OWN_NONE = 2'd3} owner_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [6:0]    LINE_LEN   = 7'(LINE_BYTES);

   state_t        state_q, state_d;
   owner_t        owner, gnt;
   logic [SW-1:0] starve_cnt;
   logic          drop;
   logic          do_grant, do_abort, do_capture, set_drop, do_finish;
   logic [31:0]   masked_word;

   assign fsm_state = state_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Winner selection lives here; ageing lets IF overtake LSB once the limit is hit.
   always_comb begin
      state_d = state_q;
      gnt     = OWN_NONE;
      case (state_q)
         IDLE: begin
            if (rdy && !rollback) begin
               if (if_req && starve_cnt == STARVE_MAX) gnt = OWN_IF;
               else if (lsb_req)                      gnt = OWN_LSB;
               else if (if_req)                       gnt = OWN_IF;
`ifdef PREFETCH_EN
               else if (pf_req)                       gnt = OWN_PF;
`endif
               if (gnt != OWN_NONE) state_d = BUSY;
            end
         end
         BUSY: begin
            if (rdy) begin
               if (rollback && owner == OWN_LSB && !dn_wr) state_d = IDLE;
               else if (dn_done)                           state_d = RESP;
            end
         end
         RESP: if (rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      do_grant   = 1'b0;
      do_abort   = 1'b0;
      do_capture = 1'b0;
      set_drop   = 1'b0;
      do_finish  = 1'b0;
      case (state_q)
         IDLE: do_grant = (gnt != OWN_NONE);
         BUSY: begin
            if (rdy) begin
               do_abort   = rollback && owner == OWN_LSB && !dn_wr;
               set_drop   = rollback && owner != OWN_LSB;
               do_capture = dn_done && !(rollback && owner == OWN_LSB && !dn_wr);
            end
         end
         RESP:    do_finish = rdy;
         default: ;
      endcase
   end

   always_comb begin
      case (dn_len[2:0])
         3'd1:    masked_word = {24'b0, rd_line[7:0]};
         3'd2:    masked_word = {16'b0, rd_line[15:0]};
         default: masked_word = rd_line[31:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         drop       <= 1'b0;
         dn_en      <= 1'b0;
         dn_wr      <= 1'b0;
         dn_addr    <= '0;
         dn_len     <= '0;
         dn_wdata   <= '0;
         rd_line    <= '0;
         lsb_rdata  <= '0;
         lsb_done   <= 1'b0;
         if_done    <= 1'b0;
`ifdef PREFETCH_EN
         pf_done    <= 1'b0;
`endif
      end else begin
         // Done pulses are single-cycle regardless of rdy.
         lsb_done <= 1'b0;
         if_done  <= 1'b0;
`ifdef PREFETCH_EN
         pf_done  <= 1'b0;
`endif
         if (state_q == IDLE && rdy) begin
            if (!if_req || gnt == OWN_IF) starve_cnt <= '0;
            else if (gnt == OWN_LSB)      starve_cnt <= starve_cnt + 1'b1;
         end
         if (do_grant) begin
            owner <= gnt;
            dn_en <= 1'b1;
            case (gnt)
               OWN_LSB: begin
                  dn_wr    <= lsb_wr;
                  dn_addr  <= lsb_addr;
                  dn_len   <= {4'b0, lsb_len};
                  dn_wdata <= lsb_wdata;
               end
`ifdef PREFETCH_EN
               OWN_PF: begin
                  dn_wr    <= 1'b0;
                  dn_addr  <= pf_addr;
                  dn_len   <= LINE_LEN;
                  dn_wdata <= '0;
               end
`endif
               default: begin
                  dn_wr    <= 1'b0;
                  dn_addr  <= if_addr;
                  dn_len   <= LINE_LEN;
                  dn_wdata <= '0;
               end
            endcase
         end
         if (do_abort) dn_en <= 1'b0;
         if (do_capture) begin
            dn_en   <= 1'b0;
            rd_line <= dn_rdata;
         end
         if (set_drop) drop <= 1'b1;
         if (do_finish) begin
            drop <= 1'b0;
            case (owner)
               OWN_LSB: begin
                  lsb_done  <= 1'b1;
                  lsb_rdata <= masked_word;
               end
               OWN_IF:  if_done <= !drop;
`ifdef PREFETCH_EN
               OWN_PF:  pf_done <= !drop;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: loads/stores, masking, ageing, rollback, rdy stall, reset.
// Define PREFETCH_EN to also exercise the prefetch requester.
module tb_mem_arbiter;

   localparam int LB = 16;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic            clk = 1'b0;
   logic            rst, rdy, rollback;
   logic            lsb_req, lsb_wr;
   logic [31:0]     lsb_addr, lsb_wdata;
   logic [2:0]      lsb_len;
   logic            lsb_done;
   logic [31:0]     lsb_rdata;
   logic            if_req;
   logic [31:0]     if_addr;
   logic            if_done;
`ifdef PREFETCH_EN
   logic            pf_req;
   logic [31:0]     pf_addr;
   logic            pf_done;
`endif
   logic [LB*8-1:0] rd_line;
   logic            dn_en, dn_wr;
   logic [31:0]     dn_addr, dn_wdata;
   logic [6:0]      dn_len;
   logic            dn_done;
   logic [LB*8-1:0] dn_rdata;
   logic [1:0]      fsm_state;

   int vectors     = 0;
   int miscompares = 0;
   logic [1:0] exp_q[$];

   mem_arbiter #(.LINE_BYTES(LB), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
`ifdef PREFETCH_EN
      .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done),
`endif
      .rd_line(rd_line), .dn_en(dn_en), .dn_wr(dn_wr), .dn_addr(dn_addr),
      .dn_len(dn_len), .dn_wdata(dn_wdata), .dn_done(dn_done), .dn_rdata(dn_rdata),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lsb_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wdata,
                          input logic [31:0] rword, input logic [31:0] exp_rdata);
      lsb_req = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_wdata = wdata;
      tick();
      check({tag, ".dn_en"}, dn_en, 1'b1);
      check({tag, ".dn_addr"}, dn_addr, addr);
      check({tag, ".dn_len"}, dn_len, {4'b0, len});
      check({tag, ".dn_wr"}, dn_wr, wr);
      if (wr) check({tag, ".dn_wdata"}, dn_wdata, wdata);
      dn_rdata = {96'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3, rword};
      dn_done  = 1'b1;
      tick();
      dn_done = 1'b0;
      check({tag, ".resp_dn_en"}, dn_en, 1'b0);
      check({tag, ".resp_no_done"}, lsb_done, 1'b0);
      tick();
      check({tag, ".lsb_done"}, lsb_done, 1'b1);
      check({tag, ".lsb_rdata"}, lsb_rdata, exp_rdata);
      check({tag, ".gap_dn_en"}, dn_en, 1'b0);
      lsb_req = 1'b0;
      tick();
      check({tag, ".done_pulse"}, lsb_done, 1'b0);
   endtask

   initial begin
      logic [1:0] obs_owner;
      int         lsb_cnt;
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
      if_req = 1'b0; if_addr = '0;
`ifdef PREFETCH_EN
      pf_req = 1'b0; pf_addr = '0;
`endif
      dn_done = 1'b0; dn_rdata = '0;
      tick(); tick();
      check("rst.dn_en", dn_en, 1'b0);
      check("rst.dn_addr", dn_addr, 32'h0);
      check("rst.dn_len", dn_len, 7'h0);
      check("rst.lsb_rdata", lsb_rdata, 32'h0);
      check("rst.rd_line", rd_line, 128'h0);
      check("rst.state", fsm_state, S_IDLE);
      rst = 1'b0;
      tick();

      // Basic loads with byte-lane masking, then a store
      lsb_txn("load4", 1'b0, 32'h0000_1004, 3'd4, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      lsb_txn("load1", 1'b0, 32'h0000_2001, 3'd1, 32'h0, 32'h1234_5678, 32'h0000_0078);
      lsb_txn("load2", 1'b0, 32'h0000_2002, 3'd2, 32'h0, 32'h1234_5678, 32'h0000_5678);
      lsb_txn("store", 1'b1, 32'h0000_3000, 3'd4, 32'hCAFE_F00D, 32'h0, 32'h0);

      // IF refill
      if_req = 1'b1; if_addr = 32'h0000_4000;
      tick();
      check("if.dn_addr", dn_addr, 32'h0000_4000);
      check("if.dn_len", dn_len, 7'd16);
      check("if.state", fsm_state, S_BUSY);
      dn_rdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; dn_done = 1'b1;
      tick();
      dn_done = 1'b0;
      check("if.resp_state", fsm_state, S_RESP);
      tick();
      check("if.if_done", if_done, 1'b1);
      check("if.rd_line", rd_line, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
      if_req = 1'b0;
      tick();

      // Starvation ageing: LSB x4, IF, LSB x2
      exp_q = {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      lsb_cnt = 0;
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd4; lsb_addr = 32'h0000_0100;
      if_req = 1'b1; if_addr = 32'h0000_8000;
      for (int g = 0; g < 7; g++) begin
         tick();
         check("starve.dn_en", dn_en, 1'b1);
         obs_owner = (dn_len == 7'd16) ? 2'd1 : 2'd0;
         check("starve.grant", obs_owner, exp_q.pop_front());
         dn_rdata = 128'h1; dn_done = 1'b1;
         tick();
         dn_done = 1'b0;
         tick();
         if (obs_owner == 2'd1) begin
            check("starve.if_done", if_done, 1'b1);
            if_req = 1'b0;
         end else begin
            check("starve.lsb_done", lsb_done, 1'b1);
            lsb_cnt++;
            lsb_addr = lsb_addr + 32'd4;
            if (lsb_cnt == 6) lsb_req = 1'b0;
         end
      end
      tick();
      check("starve.idle", dn_en, 1'b0);

      // Rollback on in-flight load: abort, no done
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h0000_5000; lsb_len = 3'd4;
      tick();
      check("rbload.busy", fsm_state, S_BUSY);
      rollback = 1'b1; lsb_req = 1'b0;
      tick();
      rollback = 1'b0;
      check("rbload.dn_en", dn_en, 1'b0);
      check("rbload.state", fsm_state, S_IDLE);
      check("rbload.no_done", lsb_done, 1'b0);
      tick();
      check("rbload.no_done2", lsb_done, 1'b0);

      // Rollback on in-flight store: ignored, store completes
      lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0000_6000; lsb_wdata = 32'h0BAD_F00D;
      tick();
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("rbstore.dn_en", dn_en, 1'b1);
      check("rbstore.dn_wdata", dn_wdata, 32'h0BAD_F00D);
      dn_done = 1'b1; dn_rdata = '0;
      tick();
      dn_done = 1'b0;
      tick();
      check("rbstore.lsb_done", lsb_done, 1'b1);
      lsb_req = 1'b0; lsb_wr = 1'b0;
      tick();

      // Rollback on in-flight IF: completes downstream, if_done suppressed
      if_req = 1'b1; if_addr = 32'h0000_7000;
      tick();
      rollback = 1'b1; if_req = 1'b0;
      tick();
      rollback = 1'b0;
      check("rbif.dn_en", dn_en, 1'b1);
      dn_done = 1'b1; dn_rdata = 128'h55;
      tick();
      dn_done = 1'b0;
      check("rbif.resp", fsm_state, S_RESP);
      tick();
      check("rbif.no_done", if_done, 1'b0);
      check("rbif.idle", fsm_state, S_IDLE);

      // Rollback coincident with dn_done on IF, then a clean IF shows drop cleared
      if_req = 1'b1; if_addr = 32'h0000_7100;
      tick();
      rollback = 1'b1; dn_done = 1'b1; if_req = 1'b0;
      tick();
      rollback = 1'b0; dn_done = 1'b0;
      tick();
      check("rbifdone.no_done", if_done, 1'b0);
      if_req = 1'b1; if_addr = 32'h0000_7200;
      tick();
      dn_done = 1'b1; dn_rdata = 128'h77;
      tick();
      dn_done = 1'b0;
      tick();
      check("ifafter.if_done", if_done, 1'b1);
      if_req = 1'b0;
      tick();

      // Rollback in IDLE blocks the grant for that cycle only
      lsb_req = 1'b1; lsb_addr = 32'h0000_9000; lsb_len = 3'd4; rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("rbidle.no_grant", dn_en, 1'b0);
      tick();
      check("rbidle.grant", dn_en, 1'b1);
      dn_done = 1'b1; dn_rdata = 128'h0;
      tick();
      dn_done = 1'b0;
      // rdy low in RESP delays the done pulse
      rdy = 1'b0;
      tick(); tick();
      check("rdy.hold_state", fsm_state, S_RESP);
      check("rdy.no_done", lsb_done, 1'b0);
      rdy = 1'b1;
      tick();
      check("rdy.done", lsb_done, 1'b1);
      lsb_req = 1'b0;
      tick();

      // rdy low in IDLE blocks the grant
      rdy = 1'b0; lsb_req = 1'b1; lsb_addr = 32'h0000_A000;
      tick();
      check("rdy.no_grant", dn_en, 1'b0);
      rdy = 1'b1;
      tick();
      check("rdy.grant", dn_en, 1'b1);

      // Reset mid-transaction abandons it
      rst = 1'b1; lsb_req = 1'b0;
      tick();
      rst = 1'b0;
      check("midrst.dn_en", dn_en, 1'b0);
      check("midrst.state", fsm_state, S_IDLE);
      check("midrst.dn_addr", dn_addr, 32'h0);
      tick();
      check("midrst.no_done", lsb_done, 1'b0);

`ifdef PREFETCH_EN
      // IF beats PF; PF served after if_done
      pf_req = 1'b1; pf_addr = 32'h0000_A000; if_req = 1'b1; if_addr = 32'h0000_B000;
      tick();
      check("pf.if_first", dn_addr, 32'h0000_B000);
      dn_done = 1'b1; dn_rdata = 128'h1;
      tick();
      dn_done = 1'b0;
      tick();
      check("pf.if_done", if_done, 1'b1);
      check("pf.no_pf_done", pf_done, 1'b0);
      if_req = 1'b0;
      tick();
      check("pf.pf_addr", dn_addr, 32'h0000_A000);
      check("pf.pf_len", dn_len, 7'd16);
      dn_done = 1'b1; dn_rdata = 128'h2;
      tick();
      dn_done = 1'b0;
      tick();
      check("pf.pf_done", pf_done, 1'b1);
      check("pf.rd_line", rd_line, 128'h2);
      pf_req = 1'b0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
